// File: rtl/conv_stream_param.sv
// Parametrised 1-D valid-mode convolution engine: buffers N X samples and M taps,
// then streams N-M+1 outputs computed by P parallel MAC lanes over M/P cycles each.
module conv_stream_param #(
  parameter int unsigned XW = 8,
  parameter int unsigned FW = 8,
  parameter int unsigned N  = 128,
  parameter int unsigned M  = 32,
  parameter int unsigned P  = 8,
  localparam int unsigned YW = XW + FW + $clog2(M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [XW-1:0] s_data_x,
  input  logic                 s_valid_x,
  output logic                 s_ready_x,
  input  logic signed [FW-1:0] s_data_f,
  input  logic                 s_valid_f,
  output logic                 s_ready_f,
  input  logic                 keep_f,
  input  logic                 relu_en,
  output logic signed [YW-1:0] m_data_y,
  output logic                 m_valid_y,
  input  logic                 m_ready_y,
  output logic                 busy
);

  localparam int unsigned CPO = M / P;
  localparam int unsigned PW  = XW + FW;
  localparam int unsigned XCW = $clog2(N + 1);
  localparam int unsigned FCW = $clog2(M + 1);
  localparam int unsigned XAW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FAW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned KW  = XAW;
  localparam int unsigned JW  = (CPO > 1) ? $clog2(CPO) : 1;

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] COMP = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]            state, state_nx;
  logic [XCW-1:0]        x_cnt;
  logic [FCW-1:0]        f_cnt;
  logic [KW-1:0]         k;
  logic [JW-1:0]         j;
  logic signed [YW-1:0]  acc, mac_sum;
  logic signed [PW-1:0]  prod;
  logic                  relu_q;
  logic signed [XW-1:0]  x_mem [N];
  logic signed [FW-1:0]  f_mem [M];
  logic                  x_hs, f_hs, x_full_nx, f_full_nx, last_j, last_k;

  assign s_ready_x = (state == LOAD) && (x_cnt < XCW'(N));
  assign s_ready_f = (state == LOAD) && (f_cnt < FCW'(M));
  assign x_hs      = s_valid_x && s_ready_x;
  assign f_hs      = s_valid_f && s_ready_f;
  // Frame complete once this edge's accepts fill both buffers
  assign x_full_nx = (x_cnt == XCW'(N)) || (x_hs && (x_cnt == XCW'(N - 1)));
  assign f_full_nx = (f_cnt == FCW'(M)) || (f_hs && (f_cnt == FCW'(M - 1)));
  assign last_j    = (j == JW'(CPO - 1));
  assign last_k    = (k == KW'(N - M));

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (x_full_nx && f_full_nx) state_nx = COMP;
      COMP:    if (last_j) state_nx = OUT;
      OUT:     if (m_ready_y) state_nx = last_k ? LOAD : COMP;
      default: state_nx = LOAD;
    endcase
  end

  // One slice of P taps per COMP cycle, full-precision products
  always_comb begin
    mac_sum = acc;
    prod    = '0;
    for (int unsigned i = 0; i < P; i++) begin
      prod    = x_mem[XAW'(32'(k) + 32'(j) * P + i)] * f_mem[FAW'(32'(j) * P + i)];
      mac_sum = mac_sum + YW'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (x_hs) x_mem[XAW'(x_cnt)] <= s_data_x;
    if (f_hs) f_mem[FAW'(f_cnt)] <= s_data_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt     <= '0;
      f_cnt     <= '0;
      k         <= '0;
      j         <= '0;
      acc       <= '0;
      relu_q    <= 1'b0;
      m_valid_y <= 1'b0;
      m_data_y  <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nx != LOAD);
      case (state)
        LOAD: begin
          if (x_hs) x_cnt <= x_cnt + XCW'(1);
          if (f_hs) f_cnt <= f_cnt + FCW'(1);
          if (state_nx == COMP) begin
            j      <= '0;
            acc    <= '0;
            relu_q <= relu_en;
          end
        end
        COMP: begin
          acc <= mac_sum;
          j   <= last_j ? '0 : j + JW'(1);
          if (last_j) begin
            m_valid_y <= 1'b1;
            m_data_y  <= (relu_q && mac_sum[YW-1]) ? '0 : mac_sum;
          end
        end
        OUT: begin
          if (m_ready_y) begin
            m_valid_y <= 1'b0;
            acc       <= '0;
            if (last_k) begin
              k     <= '0;
              x_cnt <= '0;
              if (!keep_f) f_cnt <= '0;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_param.sv
// Self-checking bench for conv_stream_param: default-size instance plus a small
// N=16/M=4/P=4 instance, checked against a direct convolution model.
module tb_conv_stream_param;

  localparam int unsigned XW = 8, FW = 8, N = 128, M = 32, P = 8;
  localparam int unsigned YW = XW + FW + $clog2(M);
  localparam int unsigned NOUT = N - M + 1;
  localparam int unsigned CPO = M / P;
  localparam int unsigned YWS = 4 + 4 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic signed [XW-1:0] s_data_x;
  logic                 s_valid_x, s_ready_x;
  logic signed [FW-1:0] s_data_f;
  logic                 s_valid_f, s_ready_f;
  logic                 keep_f, relu_en;
  logic signed [YW-1:0] m_data_y;
  logic                 m_valid_y, m_ready_y, busy;

  logic signed [3:0]     sx_d, sf_d;
  logic                  sx_v, sx_r, sf_v, sf_r, s_keep, s_relu;
  logic signed [YWS-1:0] sy_d;
  logic                  sy_v, sy_r, s_busy;

  conv_stream_param #(.XW(XW), .FW(FW), .N(N), .M(M), .P(P)) dut (
    .clk(clk), .reset(reset),
    .s_data_x(s_data_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_data_f(s_data_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .keep_f(keep_f), .relu_en(relu_en),
    .m_data_y(m_data_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .busy(busy)
  );

  conv_stream_param #(.XW(4), .FW(4), .N(16), .M(4), .P(4)) dut_small (
    .clk(clk), .reset(reset),
    .s_data_x(sx_d), .s_valid_x(sx_v), .s_ready_x(sx_r),
    .s_data_f(sf_d), .s_valid_f(sf_v), .s_ready_f(sf_r),
    .keep_f(s_keep), .relu_en(s_relu),
    .m_data_y(sy_d), .m_valid_y(sy_v), .m_ready_y(sy_r),
    .busy(s_busy)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     xs [N];
  int     fs [M];
  longint expv [NOUT];

  task automatic build_expected(input bit relu);
    for (int kk = 0; kk < int'(NOUT); kk++) begin
      longint s = 0;
      for (int jj = 0; jj < int'(M); jj++) s += longint'(xs[kk + jj]) * longint'(fs[jj]);
      if (relu && s < 0) s = 0;
      expv[kk] = s;
    end
  endtask

  task automatic idle_inputs();
    s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
    s_data_x = '0; s_data_f = '0;
  endtask

  // Streams one frame in and collects outputs up to stop_at, checking each against the model
  task automatic run_frame(input bit send_f, input bit relu, input bit keep, input int vpct,
                           input int rpct, input int stall_at, input int stop_at, input string tag);
    int xi = 0, fi = 0, oi = 0, cyc = 0, ref_cyc = -1, stall_left = 0;
    bit loaded = 0, seen = 0, drop_chk = 0;
    logic signed [YW-1:0] held = '0;
    build_expected(relu);
    fi = send_f ? 0 : int'(M);
    while (oi < stop_at && cyc < 20000) begin
      @(negedge clk);
      if (drop_chk) begin
        n_checks++;
        if (m_valid_y !== 1'b0) begin
          n_fail++; $display("FAIL %s valid_drop out=%0d got=%b want=0", tag, oi, m_valid_y);
        end
        drop_chk = 0;
      end
      if (!send_f && !loaded) begin
        n_checks++;
        if (s_ready_f !== 1'b0) begin
          n_fail++; $display("FAIL %s kept_filter_ready cyc=%0d got=%b want=0", tag, cyc, s_ready_f);
        end
      end
      if (seen) begin
        n_checks++;
        if (m_valid_y !== 1'b1 || m_data_y !== held) begin
          n_fail++;
          $display("FAIL %s hold out=%0d got=%b/%0d want=1/%0d", tag, oi, m_valid_y, m_data_y, held);
        end
      end else if (m_valid_y === 1'b1) begin
        seen = 1; held = m_data_y;
        n_checks++;
        if (cyc - ref_cyc != int'(CPO) + 1) begin
          n_fail++; $display("FAIL %s latency out=%0d got=%0d want=%0d", tag, oi, cyc - ref_cyc, CPO + 1);
        end
        n_checks++;
        if (longint'(m_data_y) != expv[oi]) begin
          n_fail++; $display("FAIL %s y out=%0d got=%0d want=%0d", tag, oi, m_data_y, expv[oi]);
        end
        n_checks++;
        if (s_ready_x !== 1'b0 || s_ready_f !== 1'b0) begin
          n_fail++; $display("FAIL %s ready_in_out out=%0d got=%b%b want=00", tag, oi, s_ready_x, s_ready_f);
        end
        if (oi == stall_at) stall_left = 5;
      end
      s_valid_x = (xi < int'(N)) && (int'($urandom_range(99)) < vpct);
      s_data_x  = XW'(xs[(xi < int'(N)) ? xi : 0]);
      if (send_f) begin
        s_valid_f = (fi < int'(M)) && (int'($urandom_range(99)) < vpct);
        s_data_f  = FW'(fs[(fi < int'(M)) ? fi : 0]);
      end else begin
        s_valid_f = 1'b1;
        s_data_f  = FW'($urandom);
      end
      keep_f  = keep;
      relu_en = relu;
      if (stall_left > 0) begin
        m_ready_y = 1'b0; stall_left--;
      end else begin
        m_ready_y = int'($urandom_range(99)) < rpct;
      end
      if (s_valid_x && s_ready_x) xi++;
      if (send_f && s_valid_f && s_ready_f) fi++;
      if (!loaded && xi == int'(N) && fi == int'(M)) begin
        loaded = 1; ref_cyc = cyc;
      end
      if (m_valid_y && m_ready_y) begin
        oi++; seen = 0; drop_chk = 1; ref_cyc = cyc;
      end
      cyc++;
    end
    n_checks++;
    if (oi < stop_at) begin
      n_fail++; $display("FAIL %s timeout outputs=%0d want=%0d", tag, oi, stop_at);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic check_frame_end(input string tag, input logic want_rf);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || m_valid_y !== 1'b0 || s_ready_x !== 1'b1 || s_ready_f !== want_rf) begin
      n_fail++;
      $display("FAIL %s frame_end got busy=%b v=%b rx=%b rf=%b want 0 0 1 %b",
               tag, busy, m_valid_y, s_ready_x, s_ready_f, want_rf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if (m_valid_y !== 1'b0 || m_data_y !== '0 || busy !== 1'b0 || s_ready_x !== 1'b1 || s_ready_f !== 1'b1) begin
      n_fail++;
      $display("FAIL reset got v=%b y=%0d busy=%b rx=%b rf=%b want 0 0 0 1 1",
               m_valid_y, m_data_y, busy, s_ready_x, s_ready_f);
    end
  endtask

  task automatic test_ones();
    for (int i = 0; i < int'(N); i++) xs[i] = 1;
    for (int i = 0; i < int'(M); i++) fs[i] = 1;
    run_frame(1, 0, 0, 100, 100, -1, NOUT, "ones");
    check_frame_end("ones", 1'b1);
  endtask

  task automatic test_ramp_delta();
    for (int i = 0; i < int'(N); i++) xs[i] = i - 64;
    for (int i = 0; i < int'(M); i++) fs[i] = (i == 0) ? 1 : 0;
    run_frame(1, 0, 0, 100, 100, -1, NOUT, "ramp");
    check_frame_end("ramp", 1'b1);
  endtask

  task automatic test_extremes();
    for (int i = 0; i < int'(N); i++) xs[i] = -128;
    for (int i = 0; i < int'(M); i++) fs[i] = -128;
    run_frame(1, 0, 0, 100, 100, -1, NOUT, "max_pos");
    for (int i = 0; i < int'(M); i++) fs[i] = 127;
    run_frame(1, 0, 0, 100, 100, -1, NOUT, "max_neg");
    run_frame(1, 1, 0, 100, 100, -1, NOUT, "relu");
    check_frame_end("relu", 1'b1);
  endtask

  task automatic test_random_handshake();
    for (int i = 0; i < int'(N); i++) xs[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < int'(M); i++) fs[i] = int'($urandom_range(255)) - 128;
    run_frame(1, 0, 0, 60, 70, 10, NOUT, "random");
    check_frame_end("random", 1'b1);
  endtask

  task automatic test_keep_filter();
    for (int i = 0; i < int'(N); i++) xs[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < int'(M); i++) fs[i] = int'($urandom_range(255)) - 128;
    run_frame(1, 1, 1, 80, 80, -1, NOUT, "keep1");
    check_frame_end("keep1", 1'b0);
    for (int i = 0; i < int'(N); i++) xs[i] = int'($urandom_range(255)) - 128;
    run_frame(0, 0, 0, 80, 80, -1, NOUT, "keep2");
    check_frame_end("keep2", 1'b1);
    for (int i = 0; i < int'(M); i++) fs[i] = int'($urandom_range(255)) - 128;
    run_frame(1, 0, 0, 80, 80, -1, NOUT, "keep3");
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < int'(N); i++) xs[i] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < int'(M); i++) fs[i] = int'($urandom_range(255)) - 128;
    run_frame(1, 0, 0, 100, 100, -1, 40, "abort");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (m_valid_y !== 1'b0 || busy !== 1'b0 || s_ready_x !== 1'b1 || s_ready_f !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state got v=%b busy=%b rx=%b rf=%b want 0 0 1 1", m_valid_y, busy, s_ready_x, s_ready_f);
    end
    for (int i = 0; i < int'(N); i++) xs[i] = int'($urandom_range(255)) - 128;
    run_frame(1, 0, 0, 100, 100, -1, NOUT, "after_abort");
    check_frame_end("after_abort", 1'b1);
  endtask

  task automatic test_small_params();
    int sx [16];
    int sf [4];
    longint se [13];
    int xi = 0, fi = 0, oi = 0, cyc = 0, ref_c = -1;
    bit loaded = 0, seen = 0;
    for (int i = 0; i < 16; i++) sx[i] = int'($urandom_range(15)) - 8;
    for (int i = 0; i < 4; i++)  sf[i] = int'($urandom_range(15)) - 8;
    for (int kk = 0; kk < 13; kk++) begin
      se[kk] = 0;
      for (int jj = 0; jj < 4; jj++) se[kk] += longint'(sx[kk + jj] * sf[jj]);
    end
    while (oi < 13 && cyc < 2000) begin
      @(negedge clk);
      if (sy_v === 1'b1 && !seen) begin
        seen = 1;
        n_checks++;
        if (cyc - ref_c != 2) begin
          n_fail++; $display("FAIL small latency out=%0d got=%0d want=2", oi, cyc - ref_c);
        end
        n_checks++;
        if (longint'(sy_d) != se[oi]) begin
          n_fail++; $display("FAIL small y out=%0d got=%0d want=%0d", oi, sy_d, se[oi]);
        end
      end
      sx_v = xi < 16; sx_d = 4'(sx[(xi < 16) ? xi : 0]);
      sf_v = fi < 4;  sf_d = 4'(sf[(fi < 4) ? fi : 0]);
      sy_r = 1'b1;
      if (sx_v && sx_r) xi++;
      if (sf_v && sf_r) fi++;
      if (!loaded && xi == 16 && fi == 4) begin
        loaded = 1; ref_c = cyc;
      end
      if (sy_v && sy_r) begin
        oi++; seen = 0; ref_c = cyc;
      end
      cyc++;
    end
    @(posedge clk); #1;
    sx_v = 1'b0; sf_v = 1'b0; sy_r = 1'b0;
    n_checks++;
    if (oi != 13 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL small frame_end got outputs=%0d busy=%b want 13 0", oi, s_busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    keep_f = 1'b0; relu_en = 1'b0;
    idle_inputs();
    sx_d = '0; sf_d = '0; sx_v = 1'b0; sf_v = 1'b0; sy_r = 1'b0;
    s_keep = 1'b0; s_relu = 1'b0;
    test_reset();
    test_ones();
    test_ramp_delta();
    test_extremes();
    test_random_handshake();
    test_keep_filter();
    test_reset_mid_frame();
    test_small_params();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
